// File: rtl/axil_arb_pkg.sv
// Shared types and constants for the two-requester AXI4-Lite register arbiter.
package axil_arb_pkg;

  localparam int NUM_REQ = 2;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  // One transaction in flight: pick a requester in IDLE, then walk either
  // the write path (WADDR -> WRESP) or the read path (RADDR -> RDATA).
  typedef enum logic [2:0] {
    S_IDLE,
    S_WADDR,
    S_WRESP,
    S_RADDR,
    S_RDATA
  } state_e;

endpackage

// File: rtl/axil_reg_arbiter_if.sv
// AXI4-Lite bus bundle between the arbiter (master) and the register slave.
interface axil_reg_arbiter_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the pointer remembers who won last so a tie
// goes to the other requester. Pointer resets to 1 so requester 0 wins first.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);
  logic last_q, last_d;

  // One-hot grant: a lone requester wins outright, a tie goes to !last.
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
  end

  // Pointer moves only when a grant is actually taken.
  always_comb begin
    last_d = last_q;
    if (en && (gnt != 2'b00)) last_d = gnt[1];
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end
endmodule

// File: rtl/axil_reg_arbiter.sv
// Shares one AXI4-Lite master port between two requesters, one transaction
// at a time, with round-robin arbitration in IDLE.
module axil_reg_arbiter
  import axil_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_rdata,
  output logic [1:0]                      rsp_resp,
  axil_reg_arbiter_if.master              M_AXI
);
  state_e                  state_q, state_d;
  logic                    owner_q, owner_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;

  logic [1:0]              gnt;
  logic                    arb_en, sel;
  logic                    run;
  logic                    awvalid, wvalid, bready, arvalid, rready;
  logic                    aw_hs, w_hs, b_hs, r_hs;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;

  assign run    = !ARESET;
  assign arb_en = run && (state_q == S_IDLE);
  assign sel    = gnt[1];

  rr_arbiter2 u_rr (
    .clk (ACLK),
    .rst (ARESET),
    .req (req_valid),
    .en  (arb_en),
    .gnt (gnt)
  );

  // Bus strobes are pure functions of state so they hold until their READY;
  // everything is forced low while reset is asserted.
  always_comb begin
    awvalid   = run && (state_q == S_WADDR) && !aw_done_q;
    wvalid    = run && (state_q == S_WADDR) && !w_done_q;
    bready    = run && (state_q == S_WRESP);
    arvalid   = run && (state_q == S_RADDR);
    rready    = run && (state_q == S_RDATA);
    aw_hs     = awvalid && M_AXI.AWREADY;
    w_hs      = wvalid  && M_AXI.WREADY;
    b_hs      = bready  && M_AXI.BVALID;
    r_hs      = rready  && M_AXI.RVALID;
    sel_addr  = sel ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]  : req_addr[ADDR_WIDTH-1:0];
    sel_wdata = sel ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
    req_ready = arb_en ? gnt : 2'b00;
    rsp_valid = 2'b00;
    rsp_rdata = '0;
    rsp_resp  = OKAY;
    if (b_hs || r_hs) rsp_valid = owner_q ? 2'b10 : 2'b01;
    if (r_hs) begin
      rsp_rdata = M_AXI.RDATA;
      rsp_resp  = M_AXI.RRESP;
    end else if (b_hs) begin
      rsp_resp  = M_AXI.BRESP;
    end
  end

  assign M_AXI.AWADDR  = addr_q;
  assign M_AXI.AWVALID = awvalid;
  assign M_AXI.WDATA   = wdata_q;
  assign M_AXI.WSTRB   = {(DATA_WIDTH/8){1'b1}};
  assign M_AXI.WVALID  = wvalid;
  assign M_AXI.BREADY  = bready;
  assign M_AXI.ARADDR  = addr_q;
  assign M_AXI.ARVALID = arvalid;
  assign M_AXI.RREADY  = rready;

  // Next-state: capture the granted request, then track AW/W completion
  // independently and leave each phase on its handshake.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      S_IDLE: begin
        if (gnt != 2'b00) begin
          owner_d   = sel;
          we_d      = req_we[sel];
          addr_d    = {sel_addr[ADDR_WIDTH-1:2], 2'b00};
          wdata_d   = sel_wdata;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = req_we[sel] ? S_WADDR : S_RADDR;
        end
      end
      S_WADDR: begin
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q  || w_hs;
        if (aw_done_d && w_done_d) state_d = S_WRESP;
      end
      S_WRESP: if (b_hs) state_d = S_IDLE;
      S_RADDR: if (M_AXI.ARREADY) state_d = S_RDATA;
      S_RDATA: if (r_hs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and captured-request registers; reset abandons any transaction.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end
endmodule

// File: tb/tb_axil_reg_arbiter.sv
// Randomized bench: two request drivers, a register slave with adjustable
// READY/VALID latency, and a transaction-level model checked every cycle.
module tb_axil_reg_arbiter;
  import axil_arb_pkg::*;

  localparam int AW = 4;
  localparam int DW = 32;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic [1:0]    req_valid = '0;
  logic [1:0]    req_ready;
  logic [1:0]    req_we = '0;
  logic [2*AW-1:0] req_addr = '0;
  logic [2*DW-1:0] req_wdata = '0;
  logic [1:0]    rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;

  axil_reg_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axil_reg_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_resp  (rsp_resp),
    .M_AXI     (bus)
  );

  always #5 ACLK = ~ACLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- request drivers ----------------
  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] data;
  } cmd_t;

  cmd_t       cq[2][$];
  cmd_t       cur[2];
  bit         pend[2];
  bit         rand_mode = 0;
  logic [1:0] ready_seen = '0;

  initial begin
    cur[0] = '{1'b0, 4'h0, 32'h0};
    cur[1] = '{1'b0, 4'h0, 32'h0};
    forever begin
      @(posedge ACLK); #1;
      for (int n = 0; n < 2; n++) begin
        if (ready_seen[n]) pend[n] = 0;
        if (pend[n] && rand_mode && ($urandom % 16 == 0)) pend[n] = 0;
        if (!pend[n]) begin
          if (cq[n].size() > 0) begin
            cur[n] = cq[n].pop_front();
            pend[n] = 1;
          end else if (rand_mode && ($urandom % 3 == 0)) begin
            cur[n].we   = 1'($urandom % 2);
            cur[n].addr = 4'($urandom % 16);
            cur[n].data = $urandom;
            pend[n] = 1;
          end
        end
        req_valid[n]           = pend[n];
        req_we[n]              = cur[n].we;
        req_addr[n*AW +: AW]   = cur[n].addr;
        req_wdata[n*DW +: DW]  = cur[n].data;
      end
    end
  end

  // ---------------- register slave ----------------
  int   dly_aw = 0, dly_w = 0, dly_b = 0, dly_ar = 0, dly_r = 0;
  bit   rand_dly = 0, err_en = 0;
  logic [31:0] smem[4];

  initial begin
    int aw_c, w_c, b_c, ar_c, r_c;
    bit aw_have, w_have, ar_have;
    logic [3:0] waddr, raddr;
    logic [31:0] wdl;
    bit rst_s, awv_s, aw_hs_s, wv_s, w_hs_s, b_hs_s, arv_s, ar_hs_s, r_hs_s;
    logic [3:0] awaddr_s, araddr_s;
    logic [31:0] wdata_s;
    aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
    aw_have = 0; w_have = 0; ar_have = 0; waddr = 0; raddr = 0; wdl = 0;
    for (int i = 0; i < 4; i++) smem[i] = 0;
    bus.AWREADY = 0; bus.WREADY = 0; bus.BVALID = 0; bus.BRESP = 0;
    bus.ARREADY = 0; bus.RVALID = 0; bus.RDATA = 0; bus.RRESP = 0;
    forever begin
      @(negedge ACLK);
      rst_s = ARESET;
      awv_s = bus.AWVALID; aw_hs_s = bus.AWVALID && bus.AWREADY; awaddr_s = bus.AWADDR;
      wv_s = bus.WVALID;   w_hs_s = bus.WVALID && bus.WREADY;    wdata_s = bus.WDATA;
      b_hs_s = bus.BVALID && bus.BREADY;
      arv_s = bus.ARVALID; ar_hs_s = bus.ARVALID && bus.ARREADY; araddr_s = bus.ARADDR;
      r_hs_s = bus.RVALID && bus.RREADY;
      @(posedge ACLK); #1;
      if (rst_s) begin
        aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
        aw_have = 0; w_have = 0; ar_have = 0;
        for (int i = 0; i < 4; i++) smem[i] = 0;
        bus.BVALID = 0; bus.RVALID = 0;
      end else begin
        if (aw_hs_s) begin
          aw_have = 1; waddr = awaddr_s; aw_c = 0;
          if (rand_dly) dly_aw = $urandom % 4;
        end else if (awv_s) aw_c++;
        if (w_hs_s) begin
          w_have = 1; wdl = wdata_s; w_c = 0;
          if (rand_dly) dly_w = $urandom % 4;
        end else if (wv_s) w_c++;
        if (b_hs_s) bus.BVALID = 0;
        else if (aw_have && w_have && !bus.BVALID) begin
          if (b_c >= dly_b) begin
            smem[waddr[3:2]] = wdl;
            bus.BVALID = 1;
            bus.BRESP = (err_en && ($urandom % 4 == 0)) ? SLVERR : OKAY;
            aw_have = 0; w_have = 0; b_c = 0;
            if (rand_dly) dly_b = $urandom % 4;
          end else b_c++;
        end
        if (ar_hs_s) begin
          ar_have = 1; raddr = araddr_s; ar_c = 0;
          if (rand_dly) dly_ar = $urandom % 4;
        end else if (arv_s) ar_c++;
        if (r_hs_s) bus.RVALID = 0;
        else if (ar_have && !bus.RVALID) begin
          if (r_c >= dly_r) begin
            bus.RVALID = 1;
            bus.RDATA = smem[raddr[3:2]];
            bus.RRESP = (err_en && ($urandom % 4 == 0)) ? SLVERR : OKAY;
            ar_have = 0; r_c = 0;
            if (rand_dly) dly_r = $urandom % 4;
          end else r_c++;
        end
      end
      bus.AWREADY = (aw_c >= dly_aw);
      bus.WREADY  = (w_c >= dly_w);
      bus.ARREADY = (ar_c >= dly_ar);
    end
  end

  // ---------------- transaction model + per-cycle compare ----------------
  bit          m_act = 0;
  int          m_owner = 0, m_last = 1;
  bit          m_we = 0, m_awd = 0, m_wd = 0, m_ard = 0;
  logic [3:0]  m_addr = 0;
  logic [31:0] m_wdata = 0;
  logic [31:0] mmem[4];
  int          grant_log[$];
  int          done_cnt[2];
  logic [31:0] last_rdata[2];
  logic [1:0]  last_resp[2], last_vec[2];
  int          awhs_n = 0, whs_n = 0, rsp_n = 0, cyc = 0, aw_cyc = 0, w_cyc = 0;
  logic [3:0]  last_awaddr = 0;

  initial begin
    logic [1:0]  e_rdy, e_rv, e_rs;
    logic [31:0] e_rd;
    bit e_awv, e_wv, e_br, e_arv, e_rr, bhs, rhs;
    int pick;
    for (int i = 0; i < 4; i++) mmem[i] = 0;
    for (int n = 0; n < 2; n++) begin
      done_cnt[n] = 0; last_rdata[n] = 0; last_resp[n] = 0; last_vec[n] = 0;
    end
    forever begin
      @(negedge ACLK);
      cyc++;
      e_rdy = 0; e_rv = 0; e_rs = 0; e_rd = 0;
      e_awv = 0; e_wv = 0; e_br = 0; e_arv = 0; e_rr = 0; bhs = 0; rhs = 0;
      pick = -1;
      if (!ARESET) begin
        if (!m_act) begin
          if (req_valid == 2'b11)      pick = (m_last == 1) ? 0 : 1;
          else if (req_valid == 2'b01) pick = 0;
          else if (req_valid == 2'b10) pick = 1;
          if (pick >= 0) e_rdy[pick] = 1'b1;
        end else begin
          e_awv = m_we && !m_awd;
          e_wv  = m_we && !m_wd;
          e_br  = m_we && m_awd && m_wd;
          e_arv = !m_we && !m_ard;
          e_rr  = !m_we && m_ard;
          bhs = e_br && bus.BVALID;
          rhs = e_rr && bus.RVALID;
          if (bhs || rhs) e_rv[m_owner] = 1'b1;
          if (rhs) begin e_rd = mmem[m_addr[3:2]]; e_rs = bus.RRESP; end
          else if (bhs) e_rs = bus.BRESP;
        end
      end
      chk("req_ready", 32'(req_ready), 32'(e_rdy));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      chk("rsp_rdata", rsp_rdata, e_rd);
      chk("rsp_resp",  32'(rsp_resp), 32'(e_rs));
      chk("awvalid",   32'(bus.AWVALID), 32'(e_awv));
      chk("wvalid",    32'(bus.WVALID),  32'(e_wv));
      chk("bready",    32'(bus.BREADY),  32'(e_br));
      chk("arvalid",   32'(bus.ARVALID), 32'(e_arv));
      chk("rready",    32'(bus.RREADY),  32'(e_rr));
      if (e_awv && bus.AWVALID) chk("awaddr", 32'(bus.AWADDR), 32'(m_addr));
      if (e_wv && bus.WVALID) begin
        chk("wdata", bus.WDATA, m_wdata);
        chk("wstrb", 32'(bus.WSTRB), 32'hF);
      end
      if (e_arv && bus.ARVALID) chk("araddr", 32'(bus.ARADDR), 32'(m_addr));

      if (ARESET) begin
        m_act = 0; m_last = 1;
        for (int i = 0; i < 4; i++) mmem[i] = 0;
      end else begin
        if (e_awv && bus.AWREADY) m_awd = 1;
        if (e_wv && bus.WREADY)   m_wd = 1;
        if (e_arv && bus.ARREADY) m_ard = 1;
        if (bhs) begin mmem[m_addr[3:2]] = m_wdata; m_act = 0; end
        if (rhs) m_act = 0;
        if (pick >= 0) begin
          m_act = 1; m_owner = pick; m_last = pick;
          m_we = req_we[pick];
          m_addr = req_addr[pick*AW +: AW] & 4'hC;
          m_wdata = req_wdata[pick*DW +: DW];
          m_awd = 0; m_wd = 0; m_ard = 0;
          grant_log.push_back(pick);
        end
      end

      // Observations used by the directed sequences.
      if (bus.AWVALID && bus.AWREADY) begin awhs_n++; aw_cyc = cyc; end
      if (bus.WVALID && bus.WREADY)   begin whs_n++;  w_cyc = cyc; end
      if (bus.AWVALID) last_awaddr = bus.AWADDR;
      if (rsp_valid != 2'b00) rsp_n++;
      for (int n = 0; n < 2; n++) if (rsp_valid[n]) begin
        done_cnt[n]++;
        last_rdata[n] = rsp_rdata;
        last_resp[n]  = rsp_resp;
        last_vec[n]   = rsp_valid;
      end
      ready_seen = req_ready;
    end
  end

  // ---------------- directed sequences ----------------
  task automatic push(input int n, input bit we, input logic [3:0] a, input logic [31:0] d);
    cmd_t c;
    c.we = we; c.addr = a; c.data = d;
    cq[n].push_back(c);
  endtask

  task automatic wait_done(input int n, input int target, input string nm);
    int k = 0;
    while (done_cnt[n] < target && k < 300) begin @(negedge ACLK); k++; end
    chk(nm, 32'(done_cnt[n] >= target), 32'd1);
  endtask

  task automatic do_req(input int n, input bit we, input logic [3:0] a, input logic [31:0] d, input string nm);
    int t;
    t = done_cnt[n] + 1;
    push(n, we, a, d);
    wait_done(n, t, nm);
  endtask

  task automatic reset_pulse(input int k);
    @(posedge ACLK); #1 ARESET = 1;
    repeat (k) @(posedge ACLK);
    #1 ARESET = 0;
  endtask

  initial begin
    int b0, b1, a0, w0, r0, k;
    bit seen;
    // reset state
    @(negedge ACLK);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_awvalid",   32'(bus.AWVALID), 0);
    chk("rst_awaddr",    32'(bus.AWADDR), 0);
    repeat (2) @(posedge ACLK);
    #1 ARESET = 0;

    // write then read back on requester 0
    do_req(0, 1, 4'h0, 32'h0000_0001, "wr0_done");
    do_req(0, 0, 4'h0, 32'h0, "rd0_done");
    chk("rd0_data", last_rdata[0], 32'h0000_0001);
    chk("rd0_resp", 32'(last_resp[0]), 32'(OKAY));
    chk("rd0_vec",  32'(last_vec[0]), 32'b01);

    // simultaneous requesters alternate, requester 0 first after reset
    reset_pulse(1);
    grant_log.delete();
    b0 = done_cnt[0]; b1 = done_cnt[1];
    for (int i = 0; i < 4; i++) begin
      push(0, 1, 4'(i*4), 32'h100 + i);
      push(1, 1, 4'(i*4), 32'h200 + i);
    end
    wait_done(0, b0 + 4, "rr0_done");
    wait_done(1, b1 + 4, "rr1_done");
    chk("rr_count", grant_log.size(), 8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++) chk("rr_order", grant_log[i], i % 2);

    // AWREADY late, WREADY immediate
    dly_aw = 3; dly_w = 0;
    a0 = awhs_n; w0 = whs_n; r0 = rsp_n;
    do_req(1, 1, 4'h4, 32'h0000_00A5, "slow_aw_done");
    chk("slow_aw_hs",  awhs_n - a0, 1);
    chk("slow_w_hs",   whs_n - w0, 1);
    chk("slow_rsp",    rsp_n - r0, 1);
    chk("slow_w_first", 32'(w_cyc < aw_cyc), 1);
    dly_aw = 0;

    // unaligned address is forced to word alignment
    do_req(0, 1, 4'h7, 32'h0000_0077, "unal_done");
    chk("unal_awaddr", 32'(last_awaddr), 32'h4);
    do_req(1, 0, 4'h4, 32'h0, "unal_rd");
    chk("unal_rdata", last_rdata[1], 32'h0000_0077);

    // reset while waiting in the read-data phase
    dly_r = 6;
    b0 = done_cnt[0];
    push(0, 0, 4'h4, 32'h0);
    seen = 0; k = 0;
    while (!seen && k < 50) begin @(negedge ACLK); seen = bus.RREADY; k++; end
    chk("abort_rready_seen", 32'(seen), 1);
    r0 = rsp_n;
    @(posedge ACLK); #1 ARESET = 1;
    @(negedge ACLK);
    chk("abort_rst_rready", 32'(bus.RREADY), 0);
    chk("abort_rst_rsp",    32'(rsp_valid), 0);
    @(posedge ACLK); #1 ARESET = 0;
    dly_r = 0;
    @(negedge ACLK);
    chk("abort_idle_rready", 32'(bus.RREADY), 0);
    chk("abort_idle_arv",    32'(bus.ARVALID), 0);
    chk("abort_no_rsp",      rsp_n - r0, 0);
    chk("abort_done_cnt",    done_cnt[0], b0);
    do_req(1, 1, 4'h8, 32'h1234_5678, "post_wr");
    do_req(1, 0, 4'h8, 32'h0, "post_rd");
    chk("post_rdata", last_rdata[1], 32'h1234_5678);

    // four words split across requesters, then read back
    b0 = done_cnt[0]; b1 = done_cnt[1];
    push(0, 1, 4'h0, 32'd1); push(1, 1, 4'h4, 32'd2);
    push(0, 1, 4'h8, 32'd3); push(1, 1, 4'hC, 32'd4);
    wait_done(0, b0 + 2, "four_wr0");
    wait_done(1, b1 + 2, "four_wr1");
    for (int i = 0; i < 4; i++) begin
      do_req(i % 2, 0, 4'(i*4), 32'h0, "four_rd");
      chk("four_rdata", last_rdata[i % 2], 32'(i + 1));
    end

    // randomized traffic with random latencies/responses and a mid-run reset
    b0 = done_cnt[0] + done_cnt[1];
    rand_dly = 1; err_en = 1; rand_mode = 1;
    repeat (1500) @(negedge ACLK);
    reset_pulse(2);
    repeat (1500) @(negedge ACLK);
    rand_mode = 0;
    k = 0;
    while ((pend[0] || pend[1] || m_act) && k < 500) begin @(negedge ACLK); k++; end
    chk("rand_drain", 32'(pend[0] || pend[1] || m_act), 0);
    chk("rand_traffic", 32'(done_cnt[0] + done_cnt[1] - b0 > 100), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
